// File: rtl/alu_addsub_issue_pkg.sv
// Shared opcode constants and types for the add/sub issue stage.
// Optional build macro: ALU_SATURATE_EN (saturating capture of overflowed results).
package alu_addsub_issue_pkg;

    localparam int unsigned OPC_W              = 4;
    localparam int unsigned DATA_WIDTH_DEFAULT = 16;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t FUNC_ADD = 4'h1;
    localparam opcode_t FUNC_SUB = 4'h2;

    // Any code other than FUNC_ADD is evaluated as subtract by the unit.
    function automatic logic is_add(input opcode_t opc);
        return (opc == FUNC_ADD);
    endfunction

endpackage

// File: rtl/alu_addsub_issue_if.sv
// Request, add/sub unit and result bus of the issue stage.
// slave = issue stage view, master = requester/consumer/unit view.
interface alu_addsub_issue_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    import alu_addsub_issue_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_operand1;
    logic [DATA_WIDTH-1:0] in_operand2;
    opcode_t               in_opcode;

    logic [DATA_WIDTH-1:0] au_operand1;
    logic [DATA_WIDTH-1:0] au_operand2;
    opcode_t               au_opcode;
    logic [DATA_WIDTH-1:0] au_result;
    logic                  au_overflow;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_overflow;

    modport slave (
        input  in_valid, in_operand1, in_operand2, in_opcode,
        output in_ready,
        output au_operand1, au_operand2, au_opcode,
        input  au_result, au_overflow,
        output out_valid, out_result, out_overflow,
        input  out_ready
    );

    modport master (
        output in_valid, in_operand1, in_operand2, in_opcode,
        input  in_ready,
        input  au_operand1, au_operand2, au_opcode,
        output au_result, au_overflow,
        input  out_valid, out_result, out_overflow,
        output out_ready
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with combinational head and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_req_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i  && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_addsub_issue.sv
// Issue/capture stage around the combinational add/sub unit: request FIFO,
// registered result with valid/ready, sticky overflow. Macro: ALU_SATURATE_EN.
module alu_addsub_issue
    import alu_addsub_issue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    alu_addsub_issue_if.slave           bus,
    output logic                        sticky_ovf,
    input  logic                        sticky_clr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] operand1;
        logic [DATA_WIDTH-1:0] operand2;
        opcode_t               opcode;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    req_t                  push_req;
    req_t                  head_req;
    logic [REQ_W-1:0]      head_bits;
    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_empty;
    logic                  push;
    logic                  capture;
    logic [DATA_WIDTH-1:0] cap_result;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
    logic                  out_ovf_q, out_ovf_d;
    logic                  sticky_q, sticky_d;

    always_comb begin
        push_req          = '0;
        push_req.operand1 = bus.in_operand1;
        push_req.operand2 = bus.in_operand2;
        push_req.opcode   = bus.in_opcode;
    end

    assign fifo_empty  = (fifo_cnt == '0);
    assign bus.in_ready = (fifo_cnt != CW'(FIFO_DEPTH));
    assign push        = bus.in_valid && bus.in_ready;
    assign capture     = !fifo_empty && (!out_valid_q || bus.out_ready);

    alu_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (capture),
        .wdata_i (push_req),
        .head_o  (head_bits),
        .count_o (fifo_cnt)
    );

    assign head_req = req_t'(head_bits);

    // Idle unit inputs are forced to a known ADD of zeros.
    assign bus.au_operand1 = fifo_empty ? '0       : head_req.operand1;
    assign bus.au_operand2 = fifo_empty ? '0       : head_req.operand2;
    assign bus.au_opcode   = fifo_empty ? FUNC_ADD : head_req.opcode;

    always_comb begin
`ifdef ALU_SATURATE_EN
        // Overflowed result clamps toward the sign of operand1 (the true result sign).
        if (bus.au_overflow) begin
            cap_result = head_req.operand1[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            cap_result = bus.au_result;
        end
`else
        cap_result = bus.au_result;
`endif
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        if (capture) begin
            out_valid_d  = 1'b1;
            out_result_d = cap_result;
            out_ovf_d    = bus.au_overflow;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // A captured overflow wins over a clear in the same cycle.
    assign sticky_d = (sticky_q && !sticky_clr) || (capture && bus.au_overflow);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            sticky_q     <= sticky_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_overflow = out_ovf_q;
    assign sticky_ovf       = sticky_q;
    assign fifo_count       = fifo_cnt;

endmodule

// File: tb/tb_alu_addsub_issue.sv
// Directed + randomized bench for alu_addsub_issue with an integer reference model.
// Build with ALU_SATURATE_EN defined to check the saturating configuration.
module tb_alu_addsub_issue;
    import alu_addsub_issue_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       sticky_clr = 1'b0;
    logic       sticky_ovf;
    logic [2:0] fifo_count;

    int compared   = 0;
    int mismatched = 0;

    logic [16:0] exp_q [$];

    alu_addsub_issue_if #(.DATA_WIDTH(DW)) bus ();

    alu_addsub_issue #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .sticky_ovf (sticky_ovf),
        .sticky_clr (sticky_clr),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Add/sub unit: bit-level two's complement with sign-rule overflow.
    logic [DW-1:0] au_sum;
    assign au_sum = (bus.au_opcode == FUNC_ADD) ? bus.au_operand1 + bus.au_operand2
                                                : bus.au_operand1 - bus.au_operand2;
    assign bus.au_result   = au_sum;
    assign bus.au_overflow = (bus.au_opcode == FUNC_ADD)
        ? ((bus.au_operand1[DW-1] == bus.au_operand2[DW-1]) && (au_sum[DW-1] != bus.au_operand1[DW-1]))
        : ((bus.au_operand1[DW-1] != bus.au_operand2[DW-1]) && (au_sum[DW-1] != bus.au_operand1[DW-1]));

    // Reference: exact integer result, overflow when it leaves the 16-bit signed range.
    function automatic logic [16:0] ref_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] opc);
        int sa, sb, r;
        logic ovf;
        logic [15:0] res;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        r   = (opc == FUNC_ADD) ? sa + sb : sa - sb;
        ovf = (r > 32767) || (r < -32768);
        res = 16'(r);
`ifdef ALU_SATURATE_EN
        if (ovf) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {ovf, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op);
        bus.in_valid    = v;
        bus.in_operand1 = a;
        bus.in_operand2 = b;
        bus.in_opcode   = op;
    endtask

    task automatic drive_rand;
        logic [15:0] a, b;
        logic [3:0]  op;
        a  = 16'($urandom);
        b  = 16'($urandom);
        if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        op = $urandom_range(0, 1) ? FUNC_ADD : 4'($urandom_range(0, 15));
        drive(1'b1, a, b, op);
    endtask

    // Scoreboard: record accepted requests, check every consumed result in order.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_spurious", 32'(bus.out_valid), 32'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("out_result", 32'(bus.out_result), 32'(e[15:0]));
                    check("out_overflow", 32'(bus.out_overflow), 32'(e[16]));
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_calc(bus.in_operand1, bus.in_operand2, bus.in_opcode));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int wait_cnt;
        logic [15:0] exp_r2, exp_r3;
`ifdef ALU_SATURATE_EN
        exp_r2 = 16'h7FFF;
        exp_r3 = 16'h8000;
`else
        exp_r2 = 16'h8000;
        exp_r3 = 16'h7FFF;
`endif
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_ovf", 32'(bus.out_overflow), 32'd0);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        check("idle_au_opcode", 32'(bus.au_opcode), 32'(FUNC_ADD));
        check("idle_au_op1", 32'(bus.au_operand1), 32'd0);
        tick;
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick;

        // 1: basic add and two-cycle latency
        drive(1'b1, 16'h0003, 16'h0004, FUNC_ADD);
        tick;
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        check("t1_count_n1", 32'(fifo_count), 32'd1);
        check("t1_valid_n1", 32'(bus.out_valid), 32'd0);
        check("t1_au_op1", 32'(bus.au_operand1), 32'h3);
        check("t1_au_op2", 32'(bus.au_operand2), 32'h4);
        tick;
        check("t1_valid_n2", 32'(bus.out_valid), 32'd1);
        check("t1_result", 32'(bus.out_result), 32'h7);
        check("t1_ovf", 32'(bus.out_overflow), 32'd0);
        tick;
        check("t1_drained", 32'(bus.out_valid), 32'd0);
        check("t1_sticky", 32'(sticky_ovf), 32'd0);

        // 2: positive overflow sets sticky
        drive(1'b1, 16'h7FFF, 16'h0001, FUNC_ADD);
        tick;
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        tick;
        check("t2_result", 32'(bus.out_result), 32'(exp_r2));
        check("t2_ovf", 32'(bus.out_overflow), 32'd1);
        check("t2_sticky", 32'(sticky_ovf), 32'd1);
        tick;

        // 3: clear, then overflow capture coinciding with clear keeps sticky set
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        check("t3_cleared", 32'(sticky_ovf), 32'd0);
        drive(1'b1, 16'h8000, 16'h0001, FUNC_SUB);
        tick;
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        check("t3_sticky_set_wins", 32'(sticky_ovf), 32'd1);
        check("t3_result", 32'(bus.out_result), 32'(exp_r3));
        check("t3_ovf", 32'(bus.out_overflow), 32'd1);
        tick;
        check("t3_sticky_holds", 32'(sticky_ovf), 32'd1);
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        check("t3_cleared2", 32'(sticky_ovf), 32'd0);

        // 4: back-pressure fills output reg + FIFO, then drains in order
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_rand;
            if (bus.in_ready) acc++;
            tick;
        end
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        check("t4_accepted", 32'(acc), 32'd5);
        check("t4_in_ready", 32'(bus.in_ready), 32'd0);
        check("t4_count", 32'(fifo_count), 32'd4);
        check("t4_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_drain_valid", 32'(bus.out_valid), 32'd1);
            tick;
        end
        check("t4_drain_done", 32'(bus.out_valid), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t4_count_empty", 32'(fifo_count), 32'd0);

        // 5: full-rate push+pop, count stable
        for (int i = 0; i < 20; i++) begin
            drive_rand;
            tick;
            check("t5_count_stable", 32'(fifo_count), 32'd1);
        end
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        wait_cnt = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && wait_cnt < 20) begin
            tick;
            wait_cnt++;
        end
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5b: random valid/ready traffic, ordering via scoreboard
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) drive_rand;
            else drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick;
        end
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        bus.out_ready = 1'b1;
        wait_cnt = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && wait_cnt < 20) begin
            tick;
            wait_cnt++;
        end
        check("t5b_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t5b_count_empty", 32'(fifo_count), 32'd0);

        // 6: reset with queued requests discards everything
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand;
            tick;
        end
        drive(1'b0, 16'h0, 16'h0, FUNC_ADD);
        check("t6_queued", 32'(fifo_count), 32'd3);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_result", 32'(bus.out_result), 32'd0);
        tick;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t6_no_output", 32'(bus.out_valid), 32'd0);
        end
        check("t6_in_ready", 32'(bus.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
